writeframe: RTL and testbench
=============================

# writeframe

Parametrised serial LED-array frame writer; successor to the single-byte pixel writer. It accepts a stream of words over a valid/ready handshake and emits them as one framed transaction on the two-wire d_clk/d_out bus: a START condition, then every word of the frame, then FINISH. It sits between the pixel/command sequencer and the LED-array PMod pins, and lets a command plus its auto-increment data bytes go out in a single frame.

## Interface
- CLK_IN_HZ, 12_000_000: system clock frequency.
- BIT_RATE_HZ, 1_000_000: bus tick rate. CLK_DIV = CLK_IN_HZ/BIT_RATE_HZ, and must be ≥ 2.
- WIDTH, 8: bits per word.
- clk  in  1  system clock; all logic is on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- valid  in  1  upstream word valid.
- value  in  WIDTH  upstream word.
- last  in  1  qualifies value; high marks the final word of the frame.
- ready  out  1  holding buffer empty. A word is accepted when valid && ready.
- d_clk  out  1  bus clock; idles high.
- d_out  out  1  bus data; idles high.
- busy  out  1  a frame is pending or in flight.
- frame_done  out  1  one-cycle pulse when the frame ends.

## Operation
- Reset values: d_clk=1, d_out=1, ready=1, busy=0, frame_done=0, state=IDLE, holding buffer empty, tick counter=0.
- Holding buffer (1 entry): stores value and last. It loads on valid && ready, which drops ready on the next cycle. It empties when the shifter loads from it at a word boundary.
- The value is sampled only on handshake. valid while ready=0 is ignored; nothing is dropped silently because the sender must hold.
- Tick generator: the counter runs 0..CLK_DIV-1 and asserts tick on CLK_DIV-1.
  - In IDLE with the buffer empty, the counter is held at 0.
  - The counter never runs as a generated clock; all state changes are clk-enabled by tick.
- State machine (advances only on tick):
  - IDLE: d_clk=1, d_out=1. Buffer full → START.
  - START: d_out=0, d_clk=1. Loads the shifter from the buffer, bit index=0 → D1.
  - D1: d_clk=0, d_out=current bit → D2.
  - D2: d_clk=1, d_out held → D3.
  - D3: d_clk=1, d_out held → D4.
  - D4: d_clk=0, d_out held.
    - Bit index < WIDTH-1: index+1 → D1.
    - Word complete and word's last=1 → FINISH.
    - Word complete, last=0, buffer full: load the shifter, index=0 → D1.
    - Word complete, last=0, buffer empty → WAIT.
  - WAIT: d_clk=0, d_out held (stall). Buffer full: load the shifter → D1.
  - FINISH: d_out=0, d_clk=1 → IDLE. frame_done pulses for one clk on this tick.
- Bit order is LSB first by default (see Configuration).
- busy = (state != IDLE) || buffer full. It rises the cycle after the first handshake and falls on the cycle IDLE is re-entered.
- A single-word frame (last=1 on the first word) is legal.
- Reset mid-frame: outputs return to idle-high immediately and the buffer is cleared. The truncated frame is not resumed.

## Timing
- First-word latency: d_out falls CLK_DIV cycles after the buffer loads (first tick → START).
- Each word takes 4·WIDTH ticks. The bus clock has 50 % duty at BIT_RATE_HZ/4.
- N-word frame with no stalls: 1 + 4·WIDTH·N + 1 ticks from START to IDLE.
- Back-to-back words need no gap if the next word is accepted before the D4 tick of the final bit. ready reasserts the cycle after the shifter load, which gives 4·WIDTH·CLK_DIV-1 cycles of slack.
- A handshake on the same cycle as the shifter load is accepted: the buffer's empty/refill is resolved with load priority, then fill.
- A new frame may be accepted during FINISH. It starts at the tick after IDLE is entered, so there is at least one idle-high tick between frames.

## Configuration
- WRITEFRAME_MSB_FIRST_EN defined: each word shifts out MSB first (bit WIDTH-1 down to 0).
- WRITEFRAME_MSB_FIRST_EN undefined: each word shifts out LSB first, compatible with the existing pixel writer.
- Framing and timing are identical in both builds.

## Structure
- Package writeframe_pkg holds:
  - the state enum (IDLE, START, D1, D2, D3, D4, WAIT, FINISH);
  - a constant function computing CLK_DIV with an elaboration check that it is ≥ 2;
  - the tick-counter width ($clog2(CLK_DIV)).
- Sub-module tick_gen takes clk, rst_n, CLK_DIV, hold and produces tick. It is reusable by other PMod drivers.
- The top level contains the holding buffer, the shifter/index and the FSM.

## Test plan
- Reset idle: release rst_n and hold for 100 cycles → d_clk=1, d_out=1, ready=1, busy=0 throughout.
- Single word, 8'hA5 with last=1, CLK_DIV=12:
  - d_out falls 12 cycles after the handshake;
  - bits sample on d_clk rising as 1,0,1,0,0,1,0,1;
  - FINISH then idle, 34 ticks total;
  - frame_done pulses once.
- Three words 8'h40, 8'h01, 8'hFF (last on the third), sent back-to-back → one START, 24 bit periods with no WAIT, one FINISH, 98 ticks.
- Stall: send word 1 (last=0) and delay word 2 by 2000 cycles → d_clk held low in WAIT, then the frame resumes correctly with no extra START.
- Reset mid-frame: assert rst_n during bit 3 of the second word → outputs high within the same cycle, busy=0, ready=1. The next frame transmits cleanly.
- Build with WRITEFRAME_MSB_FIRST_EN and send 8'h80 → first sampled bit is 1, the remaining seven are 0.

Source files
------------

// File: rtl/writeframe_pkg.sv
// Shared types and elaboration helpers for the writeframe LED-array frame writer.
// Bit order is selected by WRITEFRAME_MSB_FIRST_EN (see writeframe.sv).
package writeframe_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        D1,
        D2,
        D3,
        D4,
        WAIT,
        FINISH
    } state_t;

    // System clocks per bus tick; the top level rejects results below 2.
    function automatic int calc_clk_div(input longint clk_hz, input longint bit_hz);
        return int'(clk_hz / bit_hz);
    endfunction

    function automatic int cnt_width(input int div);
        return (div > 2) ? $clog2(div) : 1;
    endfunction

endpackage

// File: rtl/writeframe_if.sv
// Upstream word stream into writeframe: a word moves when valid && ready on a rising clk.
// value and last are only meaningful while valid is high; the sender holds them until accepted.
interface writeframe_if #(
    parameter int WIDTH = 8
);
    logic             valid;
    logic [WIDTH-1:0] value;
    logic             last;
    logic             ready;

    modport master (output valid, output value, output last, input ready);
    modport slave  (input valid, input value, input last, output ready);
endinterface

// File: rtl/writeframe_tick_gen.sv
// Clock-enable generator: tick is high for one clk every CLK_DIV cycles; hold parks the count at 0.
module tick_gen
    import writeframe_pkg::*;
#(
    parameter int CLK_DIV = 12
) (
    input  logic clk,
    input  logic rst_n,
    input  logic hold,
    output logic tick
);

    localparam int CW = cnt_width(CLK_DIV);
    localparam logic [CW-1:0] LAST_COUNT = CW'(CLK_DIV - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (hold || count == LAST_COUNT) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    assign tick = !hold && (count == LAST_COUNT);

endmodule

// File: rtl/writeframe.sv
// Frame writer: buffers upstream words and sends START, every word, FINISH on d_clk/d_out.
// Define WRITEFRAME_MSB_FIRST_EN to shift each word MSB first; the default is LSB first.
module writeframe
    import writeframe_pkg::*;
#(
    parameter int CLK_IN_HZ   = 12_000_000,
    parameter int BIT_RATE_HZ = 1_000_000,
    parameter int WIDTH       = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    writeframe_if.slave up,
    output logic        d_clk,
    output logic        d_out,
    output logic        busy,
    output logic        frame_done,
    output state_t      state
);

    localparam int CLK_DIV = calc_clk_div(CLK_IN_HZ, BIT_RATE_HZ);
    localparam int IW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);

    generate
        if (CLK_DIV < 2) begin : g_div_check
            $error("writeframe: CLK_IN_HZ/BIT_RATE_HZ must be at least 2");
        end
    endgenerate

    state_t           state_next;
    logic             tick;
    logic             load;
    logic             buf_full;
    logic [WIDTH-1:0] buf_value;
    logic             buf_last;
    logic [WIDTH-1:0] shift_q;
    logic             shift_last;
    logic [IW-1:0]    idx;
    logic             cur_bit;

    tick_gen #(.CLK_DIV(CLK_DIV)) u_tick_gen (
        .clk  (clk),
        .rst_n(rst_n),
        .hold (state == IDLE && !buf_full),
        .tick (tick)
    );

    assign up.ready = !buf_full;

    // A load and a fill in the same cycle leave the buffer full with the new word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_full  <= 1'b0;
            buf_value <= '0;
            buf_last  <= 1'b0;
        end else begin
            if (load) begin
                buf_full <= 1'b0;
            end
            if (up.valid && up.ready) begin
                buf_full  <= 1'b1;
                buf_value <= up.value;
                buf_last  <= up.last;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q    <= '0;
            shift_last <= 1'b0;
            idx        <= '0;
        end else if (load) begin
            shift_q    <= buf_value;
            shift_last <= buf_last;
            idx        <= '0;
        end else if (tick && state == D4 && idx != LAST_IDX) begin
            idx <= idx + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        load       = 1'b0;
        if (tick) begin
            case (state)
                IDLE:   if (buf_full) state_next = START;
                START: begin
                    load       = 1'b1;
                    state_next = D1;
                end
                D1:     state_next = D2;
                D2:     state_next = D3;
                D3:     state_next = D4;
                D4: begin
                    if (idx != LAST_IDX) begin
                        state_next = D1;
                    end else if (shift_last) begin
                        state_next = FINISH;
                    end else if (buf_full) begin
                        load       = 1'b1;
                        state_next = D1;
                    end else begin
                        state_next = WAIT;
                    end
                end
                WAIT: begin
                    if (buf_full) begin
                        load       = 1'b1;
                        state_next = D1;
                    end
                end
                FINISH: state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

`ifdef WRITEFRAME_MSB_FIRST_EN
    assign cur_bit = shift_q[LAST_IDX - idx];
`else
    assign cur_bit = shift_q[idx];
`endif

    // Bus pins decode straight from registered state so reset forces idle-high at once.
    always_comb begin
        d_clk = 1'b1;
        d_out = 1'b1;
        case (state)
            START:  d_out = 1'b0;
            D1: begin
                d_clk = 1'b0;
                d_out = cur_bit;
            end
            D2, D3: d_out = cur_bit;
            D4, WAIT: begin
                d_clk = 1'b0;
                d_out = cur_bit;
            end
            FINISH: d_out = 1'b0;
            default: begin
                d_clk = 1'b1;
                d_out = 1'b1;
            end
        endcase
    end

    assign busy       = (state != IDLE) || buf_full;
    assign frame_done = tick && (state == FINISH);

endmodule

// File: tb/tb_writeframe.sv
// Directed bench for writeframe at CLK_DIV=12, WIDTH=8; honours WRITEFRAME_MSB_FIRST_EN.
// Samples are taken on every d_clk rise; FINISH also raises d_clk with d_out low, adding a trailing 0.
module tb_writeframe;
    import writeframe_pkg::*;

    logic   clk;
    logic   rst_n;
    logic   d_clk;
    logic   d_out;
    logic   busy;
    logic   frame_done;
    state_t state;

    writeframe_if #(.WIDTH(8)) up ();

    writeframe #(
        .CLK_IN_HZ  (12_000_000),
        .BIT_RATE_HZ(1_000_000),
        .WIDTH      (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .up        (up),
        .d_clk     (d_clk),
        .d_out     (d_out),
        .busy      (busy),
        .frame_done(frame_done),
        .state     (state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int hs_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // bus monitor
    logic got_q[$];
    int   starts = 0, stops = 0, dones = 0;
    int   fall_cyc = 0, rise_cyc = 0;
    int   low_run = 0, max_low = 0;
    logic pc = 1'b1, pd = 1'b1;

    always @(negedge clk) begin
        if (rst_n) begin
            if (!pc && d_clk) got_q.push_back(d_out);
            if (pc && d_clk && pd && !d_out) begin
                starts++;
                fall_cyc = cyc;
            end
            if (pc && d_clk && !pd && d_out) begin
                stops++;
                rise_cyc = cyc;
            end
            if (!d_clk) low_run++;
            else low_run = 0;
            if (low_run > max_low) max_low = low_run;
            if (frame_done) dones++;
        end
        pc = d_clk;
        pd = d_out;
    end

    function automatic logic [63:0] pack_got();
        logic [63:0] v;
        v = '0;
        for (int i = 0; i < got_q.size() && i < 64; i++) v[i] = got_q[i];
        return v;
    endfunction

    // driver tasks
    task automatic clear_mon();
        got_q.delete();
        starts = 0;
        stops = 0;
        dones = 0;
        low_run = 0;
        max_low = 0;
    endtask

    task automatic send_word(input logic [7:0] v, input logic l);
        int budget;
        @(negedge clk);
        up.valid = 1'b1;
        up.value = v;
        up.last = l;
        budget = 0;
        while (!up.ready && budget < 5000) begin
            @(negedge clk);
            budget++;
        end
        checks++;
        if (up.ready !== 1'b1) begin
            failures++;
            $display("FAIL handshake_timeout ready=%b required=1", up.ready);
        end
        @(posedge clk);
        #1;
        hs_cyc = cyc;
        up.valid = 1'b0;
    endtask

    task automatic wait_idle();
        int budget;
        budget = 0;
        while (busy && budget < 20000) begin
            @(negedge clk);
            budget++;
        end
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL idle_timeout busy=%b required=0", busy);
        end
    endtask

    // tests
    task automatic test_reset();
        rst_n = 1'b0;
        up.valid = 1'b0;
        up.value = '0;
        up.last = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if (state !== IDLE) begin
            failures++;
            $display("FAIL reset_state state=%0d required=%0d", state, IDLE);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            checks++;
            if ({d_clk, d_out, up.ready, busy, frame_done} !== 5'b11100) begin
                failures++;
                $display("FAIL reset_idle cycle=%0d d_clk,d_out,ready,busy,done=%b required=11100",
                         i, {d_clk, d_out, up.ready, busy, frame_done});
                break;
            end
        end
    endtask

    task automatic test_single_word();
        clear_mon();
        send_word(8'hA5, 1'b1);
        wait_idle();
        checks++;
        if (fall_cyc - hs_cyc !== 12) begin
            failures++;
            $display("FAIL single_latency got=%0d required=12", fall_cyc - hs_cyc);
        end
        checks++;
        if (got_q.size() !== 9 || pack_got() !== 64'h0A5) begin
            failures++;
            $display("FAIL single_bits n=%0d bits=%h required n=9 bits=0a5", got_q.size(), pack_got());
        end
        checks++;
        if (rise_cyc - fall_cyc !== 34 * 12) begin
            failures++;
            $display("FAIL single_duration got=%0d required=%0d", rise_cyc - fall_cyc, 34 * 12);
        end
        checks++;
        if (dones !== 1 || starts !== 1 || stops !== 1) begin
            failures++;
            $display("FAIL single_framing done=%0d start=%0d stop=%0d required 1/1/1", dones, starts, stops);
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] exp_bits;
`ifdef WRITEFRAME_MSB_FIRST_EN
        exp_bits = 64'h00FF8002;
`else
        exp_bits = 64'h00FF0140;
`endif
        clear_mon();
        send_word(8'h40, 1'b0);
        send_word(8'h01, 1'b0);
        send_word(8'hFF, 1'b1);
        wait_idle();
        checks++;
        if (got_q.size() !== 25 || pack_got() !== exp_bits) begin
            failures++;
            $display("FAIL b2b_bits n=%0d bits=%h required n=25 bits=%h", got_q.size(), pack_got(), exp_bits);
        end
        checks++;
        if (rise_cyc - fall_cyc !== 98 * 12) begin
            failures++;
            $display("FAIL b2b_duration got=%0d required=%0d", rise_cyc - fall_cyc, 98 * 12);
        end
        checks++;
        if (max_low !== 24) begin
            failures++;
            $display("FAIL b2b_no_wait max_low=%0d required=24", max_low);
        end
        checks++;
        if (dones !== 1 || starts !== 1 || stops !== 1) begin
            failures++;
            $display("FAIL b2b_framing done=%0d start=%0d stop=%0d required 1/1/1", dones, starts, stops);
        end
    endtask

    task automatic test_stall();
        clear_mon();
        send_word(8'h3C, 1'b0);
        repeat (2000) @(negedge clk);
        checks++;
        if (state !== WAIT || d_clk !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL stall_wait state=%0d d_clk=%b busy=%b required state=%0d d_clk=0 busy=1",
                     state, d_clk, busy, WAIT);
        end
        send_word(8'hC3, 1'b1);
        wait_idle();
        checks++;
        if (got_q.size() !== 17 || pack_got() !== 64'h0C33C) begin
            failures++;
            $display("FAIL stall_bits n=%0d bits=%h required n=17 bits=0c33c", got_q.size(), pack_got());
        end
        checks++;
        if (starts !== 1 || stops !== 1 || dones !== 1) begin
            failures++;
            $display("FAIL stall_framing start=%0d stop=%0d done=%0d required 1/1/1", starts, stops, dones);
        end
    endtask

    task automatic test_reset_mid_frame();
        int budget;
        clear_mon();
        send_word(8'h11, 1'b0);
        send_word(8'h22, 1'b1);
        budget = 0;
        while (got_q.size() < 11 && budget < 5000) begin
            @(negedge clk);
            budget++;
        end
        checks++;
        if (got_q.size() < 11) begin
            failures++;
            $display("FAIL midreset_reach samples=%0d required>=11", got_q.size());
        end
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({d_clk, d_out, busy, up.ready} !== 4'b1101 || state !== IDLE) begin
            failures++;
            $display("FAIL midreset_outputs d_clk,d_out,busy,ready=%b state=%0d required 1101 state=%0d",
                     {d_clk, d_out, busy, up.ready}, state, IDLE);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        clear_mon();
        send_word(8'hA5, 1'b1);
        wait_idle();
        checks++;
        if (got_q.size() !== 9 || pack_got() !== 64'h0A5 || starts !== 1 || dones !== 1) begin
            failures++;
            $display("FAIL midreset_next n=%0d bits=%h start=%0d done=%0d required n=9 bits=0a5 1/1",
                     got_q.size(), pack_got(), starts, dones);
        end
    endtask

    task automatic test_bit_order();
        logic [63:0] exp_bits;
`ifdef WRITEFRAME_MSB_FIRST_EN
        exp_bits = 64'h001;
`else
        exp_bits = 64'h080;
`endif
        clear_mon();
        send_word(8'h80, 1'b1);
        wait_idle();
        checks++;
        if (got_q.size() !== 9 || pack_got() !== exp_bits) begin
            failures++;
            $display("FAIL bit_order n=%0d bits=%h required n=9 bits=%h", got_q.size(), pack_got(), exp_bits);
        end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_back_to_back();
        test_stall();
        test_reset_mid_frame();
        test_bit_order();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
